// File: rtl/case_9_mul_share_arb.sv
// ---------------------------------------------------------------------------
// case_9_mul_share_arb
//
// Purpose:
//   One signed DIN0_WIDTH x DIN1_WIDTH multiplier shared by NUM_REQ requesters.
//   Requests are picked round-robin and carried through a two-register
//   pipeline (operand register S1, then product register S2). Each result
//   leaves tagged with the id of the requester that issued it.
//
// Ports:
//   ap_clk      in   clock, rising edge
//   ap_rst      in   synchronous active-high reset
//   req_valid   in   [NUM_REQ]             per-requester request valid
//   req_ready   out  [NUM_REQ]             one-hot (or zero) accept
//   req_din0    in   [NUM_REQ*DIN0_WIDTH]  operand A, requester i at [i*DIN0_WIDTH +: DIN0_WIDTH]
//   req_din1    in   [NUM_REQ*DIN1_WIDTH]  operand B, same packing
//   resp_valid  out                        result valid
//   resp_ready  in                         consumer accepts result
//   resp_id     out  [ID_WIDTH]            requester owning the result
//   resp_dout   out  [DOUT_WIDTH]          signed result
//
// Configuration:
//   CASE_9_MUL_ARB_SAT_EN  when defined and DOUT_WIDTH is narrower than the
//                          full product, the result saturates instead of
//                          wrapping. Undefined: low bits are kept.
// ---------------------------------------------------------------------------
module case_9_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [ID_WIDTH-1:0]              resp_id,
  output logic [DOUT_WIDTH-1:0]            resp_dout
);

  localparam int FULL_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  // Pipeline occupancy: bit 1 = S1 holds an op, bit 0 = S2 holds an op.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_S2    = 2'b01,
    OCC_S1    = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DIN0_WIDTH-1:0] s1_din0_q, s1_din0_d;
  logic [DIN1_WIDTH-1:0] s1_din1_q, s1_din1_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic [DOUT_WIDTH-1:0] s2_dout_q, s2_dout_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;

  logic                  s1_vld;
  logic                  s2_vld;
  logic                  adv1;
  logic                  adv2;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  transfer;
  logic [DIN0_WIDTH-1:0] sel_din0;
  logic [DIN1_WIDTH-1:0] sel_din1;
  logic [DOUT_WIDTH-1:0] prod_res;

  assign s1_vld = occ_q[1];
  assign s2_vld = occ_q[0];

  // S2 can move whenever it is empty or being drained; S1 can move whenever
  // it is empty or S2 makes room, so a drain, an S1 advance and a new grant
  // can all happen in the same cycle.
  assign adv2 = !s2_vld || resp_ready;
  assign adv1 = !s1_vld || adv2;

  // Round-robin search starting at rr_ptr. The index wraps at NUM_REQ so a
  // non-power-of-two requester count never produces an out-of-range id.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && req_valid[idx[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = grant_found && (grant_idx == ID_WIDTH'(i));
    end
  end

  // No grant while reset is held or while the pipeline cannot take an op.
  assign req_ready = (adv1 && !ap_rst) ? grant_onehot : '0;
  assign transfer  = |(req_valid & req_ready);

  always_comb begin
    sel_din0 = '0;
    sel_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_din0 = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_din1 = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  // Product formation between S1 and S2. Narrow outputs either wrap (the
  // behaviour of the HLS multiplier core) or, with the saturation option,
  // clamp to the representable signed range.
  generate
    if (DOUT_WIDTH >= FULL_WIDTH) begin : g_ext
      logic signed [FULL_WIDTH-1:0] full_prod;
      assign full_prod = FULL_WIDTH'($signed(s1_din0_q)) * FULL_WIDTH'($signed(s1_din1_q));
      // Size cast of a signed value sign-extends.
      assign prod_res  = DOUT_WIDTH'(full_prod);
    end else begin : g_narrow
`ifdef CASE_9_MUL_ARB_SAT_EN
      logic signed [FULL_WIDTH-1:0]       full_prod;
      logic [FULL_WIDTH-DOUT_WIDTH:0]     upper;
      assign full_prod = FULL_WIDTH'($signed(s1_din0_q)) * FULL_WIDTH'($signed(s1_din1_q));
      // The value fits when every bit from the output sign bit upward agrees.
      assign upper     = full_prod[FULL_WIDTH-1:DOUT_WIDTH-1];
      always_comb begin
        if ((upper == '0) || (upper == '1)) begin
          prod_res = full_prod[DOUT_WIDTH-1:0];
        end else if (full_prod[FULL_WIDTH-1]) begin
          prod_res = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        end else begin
          prod_res = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
      end
`else
      // Low product bits do not depend on the width the multiply is done at.
      assign prod_res = DOUT_WIDTH'(FULL_WIDTH'($signed(s1_din0_q)) * FULL_WIDTH'($signed(s1_din1_q)));
`endif
    end
  endgenerate

  always_comb begin
    occ_d     = occ_q;
    rr_ptr_d  = rr_ptr_q;
    s1_din0_d = s1_din0_q;
    s1_din1_d = s1_din1_q;
    s1_id_d   = s1_id_q;
    s2_dout_d = s2_dout_q;
    s2_id_d   = s2_id_q;

    if (adv2) begin
      s2_dout_d = prod_res;
      s2_id_d   = s1_id_q;
    end

    if (transfer) begin
      s1_din0_d = sel_din0;
      s1_din1_d = sel_din1;
      s1_id_d   = grant_idx;
      rr_ptr_d  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end

    occ_d = occ_e'({adv1 ? transfer : s1_vld, adv2 ? s1_vld : s2_vld});
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      occ_q     <= OCC_EMPTY;
      rr_ptr_q  <= '0;
      s1_din0_q <= '0;
      s1_din1_q <= '0;
      s1_id_q   <= '0;
      s2_dout_q <= '0;
      s2_id_q   <= '0;
    end else begin
      occ_q     <= occ_d;
      rr_ptr_q  <= rr_ptr_d;
      s1_din0_q <= s1_din0_d;
      s1_din1_q <= s1_din1_d;
      s1_id_q   <= s1_id_d;
      s2_dout_q <= s2_dout_d;
      s2_id_q   <= s2_id_d;
    end
  end

  assign resp_valid = s2_vld;
  assign resp_id    = s2_id_q;
  assign resp_dout  = s2_dout_q;

endmodule

// File: tb/tb_case_9_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_case_9_mul_share_arb
//
// Self-checking bench for case_9_mul_share_arb. A behavioural model keeps the
// round-robin pointer as an integer and the in-flight ops as a queue of
// {id, result, issue cycle}; it predicts grants, response timing and data.
// Honours CASE_9_MUL_ARB_SAT_EN for the expected arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_case_9_mul_share_arb;

  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_din0;
  logic [NR*W-1:0] req_din1;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [W-1:0]    resp_dout;

  case_9_mul_share_arb #(
    .NUM_REQ   (NR),
    .DIN0_WIDTH(W),
    .DIN1_WIDTH(W),
    .DOUT_WIDTH(W),
    .ID_WIDTH  (IDW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_dout (resp_dout)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int id;
    int dout;
    int t;
  } op_t;

  op_t          sb[$];
  int           rr;
  int           cyc;
  int           edges;
  int           n_checks;
  int           n_fail;
  bit           pend[NR];
  logic [W-1:0] op0[NR];
  logic [W-1:0] op1[NR];
  bit           refill;

  logic [NR-1:0]  obs_ready;
  logic           obs_valid;
  logic [IDW-1:0] obs_id;
  logic [W-1:0]   obs_dout;

  // Reference product: plain integer multiply, then wrap or clamp to 8 bits.
  function automatic int refMul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
`ifdef CASE_9_MUL_ARB_SAT_EN
    if (p > 127) p = 127;
    if (p < -128) p = -128;
`endif
    return p & 32'hFF;
  endfunction

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy);
    ap_rst     = rst;
    resp_ready = rdy;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = pend[i];
      req_din0[i*W +: W]   = op0[i];
      req_din1[i*W +: W]   = op1[i];
    end
  endtask

  // Sample at the falling edge, compare with the model, then advance the
  // model to what the coming rising edge does.
  task automatic stepCycle();
    int w;
    bit exp_valid;
    logic [NR-1:0] exp_ready;
    @(negedge ap_clk);
    obs_ready = req_ready;
    obs_valid = resp_valid;
    obs_id    = resp_id;
    obs_dout  = resp_dout;

    w = -1;
    if (!ap_rst && (sb.size() < 2 || resp_ready)) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (rr + k) % NR;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    checkOutput("req_ready", 32'(obs_ready), 32'(exp_ready));

    exp_valid = 1'b0;
    if (edges > 0) begin
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].t + 2);
      checkOutput("resp_valid", 32'(obs_valid), 32'(exp_valid));
      if (exp_valid && obs_valid) begin
        checkOutput("resp_id", 32'(obs_id), 32'(sb[0].id));
        checkOutput("resp_dout", 32'(obs_dout), 32'(sb[0].dout));
      end
    end

    if (ap_rst) begin
      sb.delete();
      rr = 0;
    end else begin
      if (exp_valid && resp_ready) void'(sb.pop_front());
      if (w >= 0) begin
        op_t e;
        e.id   = w;
        e.dout = refMul(op0[w], op1[w]);
        e.t    = cyc;
        sb.push_back(e);
        rr = (w + 1) % NR;
        if (refill) begin
          op0[w] = randOperand();
          op1[w] = randOperand();
        end else begin
          pend[w] = 1'b0;
        end
      end
    end

    @(posedge ap_clk);
    #1;
    edges++;
    cyc++;
  endtask

  task automatic resetDut(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b1, 1'b1);
      stepCycle();
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int got;
    int pulses;
    int xfer_c;
    int valid_c;
    logic [IDW-1:0] held_id;
    logic [W-1:0]   held_dout;
    logic [W-1:0]   t5_a[3];
    logic [W-1:0]   t5_b[3];
    logic [W-1:0]   t5_exp[3];

    n_checks = 0;
    n_fail   = 0;
    rr       = 0;
    cyc      = 0;
    edges    = 0;
    refill   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b1;
      op0[i]  = randOperand();
      op1[i]  = randOperand();
    end

    // Test 1: reset with all requests raised, then first grant goes to 0.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b1);
      stepCycle();
      checkOutput("t1_ready_in_reset", 32'(obs_ready), 32'h0);
      if (c > 0) begin
        checkOutput("t1_valid_in_reset", 32'(obs_valid), 32'h0);
        checkOutput("t1_dout_in_reset", 32'(obs_dout), 32'h0);
      end
    end
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("t1_first_grant", 32'(obs_ready), 32'h1);
    drain(8);

    // Test 2: requester 1 alone, -3 * 5.
    pend[1] = 1'b1;
    op0[1]  = 8'hFD;
    op1[1]  = 8'h05;
    pulses  = 0;
    xfer_c  = -100;
    valid_c = 0;
    got     = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      if (obs_ready[1]) xfer_c = c;
      if (obs_valid) begin
        pulses++;
        valid_c   = c;
        held_id   = obs_id;
        held_dout = obs_dout;
        got       = 1;
      end
    end
    checkOutput("t2_pulses", 32'(pulses), 32'd1);
    checkOutput("t2_latency", 32'(valid_c - xfer_c), 32'd2);
    if (got != 0) begin
      checkOutput("t2_id", 32'(held_id), 32'd1);
      checkOutput("t2_dout", 32'(held_dout), 32'hF1);
    end

    // Test 3: all requesters held valid after a fresh reset.
    resetDut(2);
    refill = 1'b1;
    for (int i = 0; i < NR; i++) pend[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      checkOutput($sformatf("t3_grant%0d", k), 32'(obs_ready), 32'(1) << (k % NR));
      if (k >= 2) begin
        checkOutput($sformatf("t3_rvalid%0d", k), 32'(obs_valid), 32'd1);
        checkOutput($sformatf("t3_rid%0d", k), 32'(obs_id), 32'((k - 2) % NR));
      end
    end

    // Test 4: consumer stalls for 3 cycles in the middle of the stream.
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    held_id   = obs_id;
    held_dout = obs_dout;
    checkOutput("t4_valid_stall0", 32'(obs_valid), 32'd1);
    checkOutput("t4_ready_full0", 32'(obs_ready), 32'h0);
    for (int c = 1; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0);
      stepCycle();
      checkOutput("t4_id_stable", 32'(obs_id), 32'(held_id));
      checkOutput("t4_dout_stable", 32'(obs_dout), 32'(held_dout));
      checkOutput("t4_ready_full", 32'(obs_ready), 32'h0);
    end
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("t4_resume_id", 32'(obs_id), 32'(held_id));
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycle();
    end
    refill = 1'b0;
    drain(8);

    // Test 5: arithmetic boundaries through requester 0.
    t5_a[0] = 8'd100; t5_b[0] = 8'd2;
    t5_a[1] = 8'h80;  t5_b[1] = 8'h80;
    t5_a[2] = 8'h80;  t5_b[2] = 8'd2;
`ifdef CASE_9_MUL_ARB_SAT_EN
    t5_exp[0] = 8'h7F; t5_exp[1] = 8'h7F; t5_exp[2] = 8'h80;
`else
    t5_exp[0] = 8'hC8; t5_exp[1] = 8'h00; t5_exp[2] = 8'h00;
`endif
    for (int j = 0; j < 3; j++) begin
      pend[0] = 1'b1;
      op0[0]  = t5_a[j];
      op1[0]  = t5_b[j];
      got     = 0;
      for (int c = 0; c < 6; c++) begin
        applyStimulus(1'b0, 1'b1);
        stepCycle();
        if (obs_valid && got == 0) begin
          got = 1;
          checkOutput($sformatf("t5_dout%0d", j), 32'(obs_dout), 32'(t5_exp[j]));
        end
      end
      checkOutput($sformatf("t5_seen%0d", j), 32'(got), 32'd1);
    end

    // Test 6: reset with two ops in flight flushes them.
    refill = 1'b1;
    for (int i = 0; i < NR; i++) pend[i] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1);
      stepCycle();
    end
    checkOutput("t6_busy", 32'(obs_valid), 32'd1);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    checkOutput("t6_ready_in_reset", 32'(obs_ready), 32'h0);
    refill = 1'b0;
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("t6_flushed", 32'(obs_valid), 32'd0);
    checkOutput("t6_rr_zero", 32'(obs_ready), 32'h1);
    drain(10);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op0[i]  = randOperand();
          op1[i]  = randOperand();
        end
      end
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0));
      stepCycle();
    end
    drain(12);
    checkOutput("final_idle_valid", 32'(obs_valid), 32'd0);
    checkOutput("final_idle_ready", 32'(obs_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
